// File: rtl/instr_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : instr_sequencer_if
// Purpose : Bundles the sequencer's run-control inputs, instruction word and
//           control-matrix outputs.
// Ports   : master - drives start/instr/stall/halt_req/state_machine_reset,
//                    observes state/opcode/running/instr_done/illegal
//           slave  - the sequencer side (directions reversed)
// Revision: 1.0 - initial release
// ============================================================================
interface instr_sequencer_if #(
   parameter int INSTR_WIDTH = 16
);
   logic                   start;
   logic [INSTR_WIDTH-1:0] instr;
   logic                   stall;
   logic                   halt_req;
   logic                   state_machine_reset;
   logic [1:0]             state;
   logic [3:0]             opcode;
   logic                   running;
   logic                   instr_done;
   logic                   illegal;

   modport master (
      output start, instr, stall, halt_req, state_machine_reset,
      input  state, opcode, running, instr_done, illegal
   );

   modport slave (
      input  start, instr, stall, halt_req, state_machine_reset,
      output state, opcode, running, instr_done, illegal
   );
endinterface
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : instr_sequencer
// Purpose : Generates the 2-bit phase and the opcode for the CPU control
//           matrix. Fetches the opcode in phase 0, steps through the phases
//           of that instruction and returns to phase 0. Handles run/halt,
//           memory stalls and the control matrix's abort request.
// Ports   : clock     - system clock, rising edge
//           reset     - asynchronous active-high reset
//           bus       - instr_sequencer_if.slave (start, instr, stall,
//                       halt_req, state_machine_reset -> state, opcode,
//                       running, instr_done, illegal)
// Macro   : ILLEGAL_TRAP_EN - opcodes 1000..1111 trap to HALT and set
//           illegal instead of executing as single-phase NOPs.
// Revision: 1.0 - initial release
// ============================================================================
module instr_sequencer #(
   parameter int INSTR_WIDTH = 16,
   parameter int OPCODE_LSB  = 12
) (
   input  wire logic         clock,
   input  wire logic         reset,
   instr_sequencer_if.slave  bus
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] HALT = 2'd2;

   logic [1:0]             fsm_q, fsm_d;
   logic [1:0]             phase_q, phase_d;
   logic [3:0]             opcode_q, opcode_d;
   logic                   illegal_q, illegal_d;

   logic [INSTR_WIDTH-1:0] instr_w;
   logic [3:0]             live_op;
   logic [3:0]             cur_op;
   logic [1:0]             last_phase;
   logic                   in_run;
   logic                   advance;
   logic                   at_last;
   logic                   trap;
   logic                   unused_bits;

   assign instr_w = bus.instr;
   assign live_op = instr_w[OPCODE_LSB+3:OPCODE_LSB];
   assign in_run  = (fsm_q == RUN);

   // Phase 0 decodes the live instruction word; later phases use the latch.
   assign cur_op  = (in_run && phase_q == 2'd0) ? live_op : opcode_q;

   always_comb begin
      case (cur_op)
         4'h0, 4'h1:             last_phase = 2'd1;
         4'h2, 4'h3, 4'h6, 4'h7: last_phase = 2'd3;
         4'h4, 4'h5:             last_phase = 2'd2;
         default:                last_phase = 2'd0;
      endcase
   end

   // Abort outranks stall, so an unstalled, un-aborted RUN cycle advances.
   assign advance = in_run && !bus.stall && !bus.state_machine_reset;
   assign at_last = (phase_q == last_phase);

`ifdef ILLEGAL_TRAP_EN
   assign trap        = advance && (phase_q == 2'd0) && cur_op[3];
   assign unused_bits = ^instr_w;
`else
   assign trap        = 1'b0;
   assign unused_bits = ^{instr_w, illegal_q};
`endif

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fsm_q     <= IDLE;
         phase_q   <= 2'd0;
         opcode_q  <= 4'd0;
         illegal_q <= 1'b0;
      end else begin
         fsm_q     <= fsm_d;
         phase_q   <= phase_d;
         opcode_q  <= opcode_d;
         illegal_q <= illegal_d;
      end
   end

   // Next-state logic
   always_comb begin
      fsm_d     = fsm_q;
      phase_d   = phase_q;
      opcode_d  = opcode_q;
      illegal_d = illegal_q;
      case (fsm_q)
         IDLE: begin
            if (bus.start) begin
               fsm_d   = RUN;
               phase_d = 2'd0;
            end
         end
         HALT: begin
            if (bus.start) begin
               fsm_d     = RUN;
               phase_d   = 2'd0;
               illegal_d = 1'b0;
            end
         end
         RUN: begin
            if (bus.state_machine_reset) begin
               phase_d = 2'd0;
            end else if (!bus.stall) begin
               if (phase_q == 2'd0) begin
                  opcode_d = live_op;
               end
               if (trap) begin
                  fsm_d     = HALT;
                  phase_d   = 2'd0;
                  illegal_d = 1'b1;
               end else if (at_last) begin
                  phase_d = 2'd0;
                  if (bus.halt_req) begin
                     fsm_d = HALT;
                  end
               end else begin
                  phase_d = phase_q + 2'd1;
               end
            end
         end
         default: begin
            fsm_d   = IDLE;
            phase_d = 2'd0;
         end
      endcase
   end

   // Output logic
   always_comb begin
      bus.state      = phase_q;
      bus.opcode     = cur_op;
      bus.running    = in_run;
      bus.instr_done = advance && at_last && !trap;
`ifdef ILLEGAL_TRAP_EN
      bus.illegal    = illegal_q;
`else
      bus.illegal    = 1'b0;
`endif
   end

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_instr_sequencer
// Purpose : Self-checking bench for instr_sequencer: directed vector table,
//           hand-written corner sequences and random stimulus compared with
//           a behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_instr_sequencer;

   logic clock = 1'b0;
   logic reset;

   always #5 clock = ~clock;

   instr_sequencer_if #(.INSTR_WIDTH(16)) bus ();

   instr_sequencer #(
      .INSTR_WIDTH(16),
      .OPCODE_LSB (12)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   int checks = 0;
   int errors = 0;

   // Behavioural model: mode 0=idle 1=run 2=halt
   int m_mode, m_ph, m_opq, m_ill;
   int n_mode, n_ph, n_opq, n_ill;
   int last_tab [16] = '{1, 1, 3, 3, 2, 2, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0};

   logic [1:0] s_state;
   logic [3:0] s_op;
   logic       s_run, s_done, s_ill;

   typedef struct {
      logic        st;
      logic [15:0] ins;
      logic        sl;
      logic        hr;
      logic        smr;
      logic [1:0]  e_state;
      logic [3:0]  e_op;
      logic        e_run;
      logic        e_done;
   } vec_t;

   vec_t vecs [27];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_ph = 0; m_opq = 0; m_ill = 0;
   endtask

   // Compare DUT outputs with the model and prepare the model's next state.
   task automatic model_check();
      int  cur, e_done;
      bit  adv, trap;
      n_mode = m_mode; n_ph = m_ph; n_opq = m_opq; n_ill = m_ill;
      if (reset) begin
         chk("rst_state", 16'(s_state), 16'd0);
         chk("rst_opcode", 16'(s_op), 16'd0);
         chk("rst_running", 16'(s_run), 16'd0);
         chk("rst_done", 16'(s_done), 16'd0);
         chk("rst_illegal", 16'(s_ill), 16'd0);
         n_mode = 0; n_ph = 0; n_opq = 0; n_ill = 0;
      end else begin
         cur = (m_mode == 1 && m_ph == 0) ? int'(bus.instr[15:12]) : m_opq;
         adv = (m_mode == 1) && !bus.stall && !bus.state_machine_reset;
`ifdef ILLEGAL_TRAP_EN
         trap = adv && (m_ph == 0) && (cur >= 8);
`else
         trap = 1'b0;
`endif
         e_done = (adv && m_ph == last_tab[cur] && !trap) ? 1 : 0;
         chk("m_state", 16'(s_state), 16'(m_ph));
         chk("m_opcode", 16'(s_op), 16'(cur));
         chk("m_running", 16'(s_run), (m_mode == 1) ? 16'd1 : 16'd0);
         chk("m_done", 16'(s_done), 16'(e_done));
         chk("m_illegal", 16'(s_ill), 16'(m_ill));
         if (m_mode == 1) begin
            if (bus.state_machine_reset) begin
               n_ph = 0;
            end else if (!bus.stall) begin
               if (m_ph == 0) n_opq = cur;
               if (trap) begin
                  n_mode = 2; n_ph = 0; n_ill = 1;
               end else if (m_ph == last_tab[cur]) begin
                  n_ph = 0;
                  if (bus.halt_req) n_mode = 2;
               end else begin
                  n_ph = m_ph + 1;
               end
            end
         end else if (bus.start) begin
            n_mode = 1; n_ph = 0; n_ill = 0;
         end
      end
   endtask

   // Called at posedge+1; drives inputs, samples mid-cycle, advances one edge.
   task automatic run_cycle(input logic st, input logic [15:0] ins, input logic sl,
                            input logic hr, input logic smr, input logic rs);
      bus.start               = st;
      bus.instr               = ins;
      bus.stall               = sl;
      bus.halt_req            = hr;
      bus.state_machine_reset = smr;
      reset                   = rs;
      #3;
      s_state = bus.state;
      s_op    = bus.opcode;
      s_run   = bus.running;
      s_done  = bus.instr_done;
      s_ill   = bus.illegal;
      model_check();
      @(posedge clock);
      m_mode = n_mode; m_ph = n_ph; m_opq = n_opq; m_ill = n_ill;
      #1;
   endtask

   task automatic set_vec(input int i, input logic st, input logic [15:0] ins,
                          input logic sl, input logic hr, input logic smr,
                          input logic [1:0] es, input logic [3:0] eo,
                          input logic er, input logic ed);
      vecs[i] = '{st, ins, sl, hr, smr, es, eo, er, ed};
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      //           st  instr    sl hr smr  state op    run done
      set_vec( 0, 1, 16'h2000, 0, 0, 0, 2'd0, 4'h0, 0, 0);
      set_vec( 1, 0, 16'h2000, 0, 0, 0, 2'd0, 4'h2, 1, 0);
      set_vec( 2, 0, 16'h2000, 0, 0, 0, 2'd1, 4'h2, 1, 0);
      set_vec( 3, 0, 16'h2000, 0, 0, 0, 2'd2, 4'h2, 1, 0);
      set_vec( 4, 0, 16'h2000, 0, 0, 0, 2'd3, 4'h2, 1, 1);
      set_vec( 5, 0, 16'h6000, 0, 0, 0, 2'd0, 4'h6, 1, 0);
      set_vec( 6, 0, 16'h6000, 0, 0, 0, 2'd1, 4'h6, 1, 0);
      set_vec( 7, 0, 16'h6000, 1, 0, 0, 2'd2, 4'h6, 1, 0);
      set_vec( 8, 0, 16'h6000, 1, 0, 0, 2'd2, 4'h6, 1, 0);
      set_vec( 9, 0, 16'h6000, 1, 0, 0, 2'd2, 4'h6, 1, 0);
      set_vec(10, 0, 16'h6000, 0, 0, 0, 2'd2, 4'h6, 1, 0);
      set_vec(11, 0, 16'h6000, 0, 0, 0, 2'd3, 4'h6, 1, 1);
      set_vec(12, 0, 16'h4000, 0, 0, 0, 2'd0, 4'h4, 1, 0);
      set_vec(13, 0, 16'h4000, 0, 1, 0, 2'd1, 4'h4, 1, 0);
      set_vec(14, 0, 16'h4000, 0, 1, 0, 2'd2, 4'h4, 1, 1);
      set_vec(15, 0, 16'h4000, 0, 1, 0, 2'd0, 4'h4, 0, 0);
      set_vec(16, 1, 16'h4000, 0, 0, 0, 2'd0, 4'h4, 0, 0);
      set_vec(17, 0, 16'h4000, 0, 0, 0, 2'd0, 4'h4, 1, 0);
      set_vec(18, 0, 16'h4000, 0, 0, 0, 2'd1, 4'h4, 1, 0);
      set_vec(19, 0, 16'h4000, 0, 0, 0, 2'd2, 4'h4, 1, 1);
      set_vec(20, 0, 16'h7000, 0, 0, 0, 2'd0, 4'h7, 1, 0);
      set_vec(21, 0, 16'h7000, 0, 0, 0, 2'd1, 4'h7, 1, 0);
      set_vec(22, 0, 16'h7000, 1, 1, 1, 2'd2, 4'h7, 1, 0);
      set_vec(23, 0, 16'h7000, 0, 0, 0, 2'd0, 4'h7, 1, 0);
      set_vec(24, 0, 16'h7000, 0, 0, 0, 2'd1, 4'h7, 1, 0);
      set_vec(25, 0, 16'h7000, 0, 0, 0, 2'd2, 4'h7, 1, 0);
      set_vec(26, 0, 16'h7000, 0, 0, 0, 2'd3, 4'h7, 1, 1);

      reset = 1'b1;
      bus.start = 0; bus.instr = 16'h0; bus.stall = 0;
      bus.halt_req = 0; bus.state_machine_reset = 0;
      model_reset();
      #2;
      chk("reset_state", 16'(bus.state), 16'd0);
      chk("reset_opcode", 16'(bus.opcode), 16'd0);
      chk("reset_running", 16'(bus.running), 16'd0);
      chk("reset_done", 16'(bus.instr_done), 16'd0);
      chk("reset_illegal", 16'(bus.illegal), 16'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;

      // Directed table: LDW, stalled ADD, RTR with halt, aborted SUB
      for (int i = 0; i < 27; i++) begin
         run_cycle(vecs[i].st, vecs[i].ins, vecs[i].sl, vecs[i].hr, vecs[i].smr, 1'b0);
         chk($sformatf("vec%0d_state", i), 16'(s_state), 16'(vecs[i].e_state));
         chk($sformatf("vec%0d_opcode", i), 16'(s_op), 16'(vecs[i].e_op));
         chk($sformatf("vec%0d_running", i), 16'(s_run), 16'(vecs[i].e_run));
         chk($sformatf("vec%0d_done", i), 16'(s_done), 16'(vecs[i].e_done));
         chk($sformatf("vec%0d_illegal", i), 16'(s_ill), 16'd0);
      end

      // Opcode 1111 at phase 0
`ifdef ILLEGAL_TRAP_EN
      run_cycle(0, 16'hF000, 0, 0, 0, 0);
      chk("trap_done", 16'(s_done), 16'd0);
      chk("trap_illegal_pre", 16'(s_ill), 16'd0);
      run_cycle(0, 16'hF000, 0, 0, 0, 0);
      chk("trap_running", 16'(s_run), 16'd0);
      chk("trap_illegal", 16'(s_ill), 16'd1);
      chk("trap_state", 16'(s_state), 16'd0);
      run_cycle(1, 16'h2000, 0, 0, 0, 0);
      chk("trap_illegal_hold", 16'(s_ill), 16'd1);
      run_cycle(0, 16'h2000, 0, 0, 0, 0);
      chk("trap_illegal_clear", 16'(s_ill), 16'd0);
      chk("trap_resume_run", 16'(s_run), 16'd1);
`else
      for (int i = 0; i < 3; i++) begin
         run_cycle(0, 16'hF000, 0, 0, 0, 0);
         chk("nop_done", 16'(s_done), 16'd1);
         chk("nop_state", 16'(s_state), 16'd0);
         chk("nop_opcode", 16'(s_op), 16'hF);
      end
`endif

      // Async reset between edges during LDW phase 2
      for (int n = 0; n < 8 && !(m_mode == 1 && m_ph == 2); n++) begin
         run_cycle(0, 16'h2000, 0, 0, 0, 0);
      end
      chk("areset_setup_phase", 16'(m_ph), 16'd2);
      chk("areset_pre_state", 16'(bus.state), 16'd2);
      #2;
      reset = 1'b1;
      #1;
      chk("areset_state", 16'(bus.state), 16'd0);
      chk("areset_opcode", 16'(bus.opcode), 16'd0);
      chk("areset_running", 16'(bus.running), 16'd0);
      chk("areset_done", 16'(bus.instr_done), 16'd0);
      model_reset();
      @(posedge clock);
      #1;
      run_cycle(0, 16'h2000, 0, 0, 0, 1);

      // Random stimulus against the model
      for (int i = 0; i < 3000; i++) begin
         run_cycle(($urandom_range(0, 3) == 0),
                   16'($urandom),
                   ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 7) == 0),
                   ($urandom_range(0, 9) == 0),
                   ($urandom_range(0, 127) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
